// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: steps each instruction through
// fetch/decode/execute/memory/writeback and decodes datapath strobes per state.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwr,
    output logic [1:0] npc_sel,
    output logic       irwr,
    output logic       regwr,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [1:0] ext_op,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       dm_req,
    output logic       dmwr,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MA     = 4'd2,
        MR     = 4'd3,
        MWB    = 4'd4,
        MW     = 4'd5,
        EXE    = 4'd6,
        AWB    = 4'd7,
        BR     = 4'd8,
        JMP    = 4'd9
    } state_t;

    state_t cur, nxt;

    logic is_r, i_addu, i_subu, i_jr, i_ori, i_lui, i_lw, i_sw, i_beq, i_j, i_jal;
    logic pcwr_c, irwr_c, regwr_c, dm_req_c, dmwr_c, illegal_c;

    always_comb begin
        is_r   = (op == 6'b000000);
        i_addu = is_r && (funct == 6'b100001);
        i_subu = is_r && (funct == 6'b100011);
        i_jr   = is_r && (funct == 6'b001000);
        i_ori  = (op == 6'b001101);
        i_lui  = (op == 6'b001111);
        i_lw   = (op == 6'b100011);
        i_sw   = (op == 6'b101011);
        i_beq  = (op == 6'b000100);
        i_j    = (op == 6'b000010);
        i_jal  = (op == 6'b000011);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= FETCH;
        else     cur <= nxt;
    end

    always_comb begin
        nxt       = cur;
        pcwr_c    = 1'b0;
        npc_sel   = 2'd0;
        irwr_c    = 1'b0;
        regwr_c   = 1'b0;
        reg_dst   = 2'd0;
        wd_sel    = 2'd0;
        ext_op    = 2'd0;
        alu_src_b = 1'b0;
        alu_op    = 2'd0;
        dm_req_c  = 1'b0;
        dmwr_c    = 1'b0;
        illegal_c = 1'b0;
        case (cur)
            FETCH: begin
                pcwr_c = 1'b1;
                irwr_c = 1'b1;
                nxt    = DECODE;
            end
            DECODE: begin
                if (i_lw || i_sw)                            nxt = MA;
                else if (i_addu || i_subu || i_ori || i_lui) nxt = EXE;
                else if (i_beq)                              nxt = BR;
                else if (i_j || i_jal || i_jr)               nxt = JMP;
                else begin
                    nxt       = FETCH;
                    illegal_c = 1'b1;
                end
            end
            MA: begin
                alu_src_b = 1'b1;
                ext_op    = 2'd1;
                nxt       = i_sw ? MW : MR;
            end
            MR: begin
                dm_req_c = 1'b1;
                if (mem_ready) nxt = MWB;
            end
            MWB: begin
                regwr_c = 1'b1;
                wd_sel  = 2'd1;
                nxt     = FETCH;
            end
            MW: begin
                dm_req_c = 1'b1;
                dmwr_c   = 1'b1;
                if (mem_ready) nxt = FETCH;
            end
            EXE, AWB: begin
                // ALU selects are held through writeback so the result stays valid
                if (i_subu)             alu_op = 2'd1;
                else if (i_ori || i_lui) alu_op = 2'd2;
                alu_src_b = i_ori || i_lui;
                ext_op    = i_lui ? 2'd2 : 2'd0;
                if (cur == AWB) begin
                    regwr_c = 1'b1;
                    reg_dst = is_r ? 2'd1 : 2'd0;
                    nxt     = FETCH;
                end else begin
                    nxt = AWB;
                end
            end
            BR: begin
                alu_op  = 2'd1;
                npc_sel = 2'd1;
                pcwr_c  = zero;
                nxt     = FETCH;
            end
            JMP: begin
                pcwr_c  = 1'b1;
                npc_sel = i_jr ? 2'd3 : 2'd2;
                if (i_jal) begin
                    regwr_c = 1'b1;
                    reg_dst = 2'd2;
                    wd_sel  = 2'd2;
                end
                nxt = FETCH;
            end
            default: nxt = FETCH;
        endcase
    end

    assign pcwr    = pcwr_c    & ~rst;
    assign irwr    = irwr_c    & ~rst;
    assign regwr   = regwr_c   & ~rst;
    assign dm_req  = dm_req_c  & ~rst;
    assign dmwr    = dmwr_c    & ~rst;
    assign illegal = illegal_c & ~rst;
    assign state   = cur;

endmodule
